// File: rtl/dylock_pkg.sv
// Shared types and constants for the dynamic-lock unlock controller.
// Holds the FSM state encoding and the 4-bit substitution table.
package dylock_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_ARMING   = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_LOCKOUT  = 2'd3
    } dylock_state_t;

    // Entry n lives at bits [4n+3:4n]; table 0..F -> 8,4,E,8,2,D,C,1,5,B,F,2,3,E,1,7.
    localparam logic [63:0] SBOX_TBL = 64'h71E3_2FB5_1CD2_8E48;

    function automatic logic [3:0] sbox_lookup(input logic [3:0] nib);
        return SBOX_TBL[{nib, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/dylock_sbox4.sv
// Combinational 4-bit substitution box, one per key nibble.
module dylock_sbox4 (
    input  logic [3:0] nib,
    output logic [3:0] tk
);
    import dylock_pkg::*;

    assign tk = sbox_lookup(nib);

endmodule

// File: rtl/dylock_unlock_ctrl.sv
// Unlock controller: transforms the static key nibble-wise, compares it with the
// expected key, and unlocks after THRESH consecutive valid matches.
//
// state       | meaning
// ST_LOCKED   | no run in progress, set = 0
// ST_ARMING   | run of valid hits in progress, below THRESH
// ST_UNLOCKED | threshold reached, set = 1
// ST_LOCKOUT  | MAX_FAIL misses seen, frozen until rst
module dylock_unlock_ctrl #(
    parameter  int KEY_W    = 16,
    parameter  int THRESH   = 8,
    parameter  int MAX_FAIL = 0,
    parameter  int STICKY   = 1,
    localparam int CNT_W    = $clog2(THRESH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [KEY_W-1:0] static_key,
    input  logic [KEY_W-1:0] correct_tk,
    output logic             set,
    output logic             match,
    output logic             lockout,
    output logic [CNT_W-1:0] match_cnt
);
    import dylock_pkg::*;

    localparam int NIB    = KEY_W / 4;
    localparam int FAIL_W = (MAX_FAIL > 0) ? $clog2(MAX_FAIL + 1) : 1;

    if (((KEY_W % 4) != 0) || (KEY_W < 4)) begin : g_bad_key_w
        $error("dylock_unlock_ctrl: KEY_W must be a positive multiple of 4");
    end
    if (THRESH < 1) begin : g_bad_thresh
        $error("dylock_unlock_ctrl: THRESH must be at least 1");
    end

    logic [KEY_W-1:0] tk_comb;
    logic [KEY_W-1:0] tk1;
    logic [KEY_W-1:0] ref1;
    logic             v1;
    logic             hit;
    logic             miss;

    for (genvar i = 0; i < NIB; i++) begin : g_sbox
        dylock_sbox4 u_sbox (
            .nib (static_key[4*i +: 4]),
            .tk  (tk_comb[4*i +: 4])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            tk1   <= '0;
            ref1  <= '0;
            match <= 1'b0;
        end else begin
            v1    <= key_valid;
            tk1   <= tk_comb;
            ref1  <= correct_tk;
            match <= hit;
        end
    end

    assign hit  = v1 && (tk1 == ref1);
    assign miss = v1 && !hit;

    dylock_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [FAIL_W-1:0] fail_q, fail_d, fail_inc;
    logic             fail_trip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOCKED;
            cnt_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
        end
    end

    // Failure counter saturates at MAX_FAIL; with lockout disabled it stays at zero.
    always_comb begin
        fail_inc = fail_q;
        if ((MAX_FAIL > 0) && (fail_q != FAIL_W'(MAX_FAIL))) begin
            fail_inc = fail_q + FAIL_W'(1);
        end
        fail_trip = (MAX_FAIL > 0) && (fail_inc == FAIL_W'(MAX_FAIL));
        cnt_inc   = cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        case (state_q)
            ST_LOCKED, ST_ARMING: begin
                if (hit) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(THRESH)) begin
                        state_d = ST_UNLOCKED;
                        fail_d  = '0;
                    end else begin
                        state_d = ST_ARMING;
                    end
                end else if (miss) begin
                    cnt_d   = '0;
                    fail_d  = fail_inc;
                    state_d = fail_trip ? ST_LOCKOUT : ST_LOCKED;
                end
            end
            ST_UNLOCKED: begin
                if ((STICKY == 0) && miss) begin
                    cnt_d   = '0;
                    fail_d  = fail_inc;
                    state_d = fail_trip ? ST_LOCKOUT : ST_LOCKED;
                end
            end
            ST_LOCKOUT: begin
                state_d = ST_LOCKOUT;
            end
            default: begin
                state_d = ST_LOCKED;
            end
        endcase
    end

    assign match_cnt = cnt_q;
    assign set       = (state_q == ST_UNLOCKED);
    assign lockout   = (state_q == ST_LOCKOUT);

endmodule

// File: tb/tb_dylock_unlock_ctrl.sv
// Self-checking bench for dylock_unlock_ctrl: four parameterisations driven with
// directed and random samples, checked against a behavioural model every cycle.
module tb_dylock_unlock_ctrl;

    localparam int NDUT = 4;

    int kw [NDUT] = '{16, 16, 32, 4};
    int th [NDUT] = '{8, 8, 3, 1};
    int mf [NDUT] = '{0, 3, 0, 2};
    int st [NDUT] = '{1, 1, 0, 0};
    int sb [16]   = '{8, 4, 14, 8, 2, 13, 12, 1, 5, 11, 15, 2, 3, 14, 1, 7};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  vld;
    logic [31:0] key [NDUT];
    logic [31:0] rf  [NDUT];
    logic [3:0]  d_set, d_match, d_lo;
    logic [3:0]  c0, c1;
    logic [1:0]  c2;
    logic [0:0]  c3;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    dylock_unlock_ctrl #(.KEY_W(16), .THRESH(8), .MAX_FAIL(0), .STICKY(1)) u0 (
        .clk(clk), .rst(rst), .key_valid(vld[0]), .static_key(key[0][15:0]),
        .correct_tk(rf[0][15:0]), .set(d_set[0]), .match(d_match[0]),
        .lockout(d_lo[0]), .match_cnt(c0));
    dylock_unlock_ctrl #(.KEY_W(16), .THRESH(8), .MAX_FAIL(3), .STICKY(1)) u1 (
        .clk(clk), .rst(rst), .key_valid(vld[1]), .static_key(key[1][15:0]),
        .correct_tk(rf[1][15:0]), .set(d_set[1]), .match(d_match[1]),
        .lockout(d_lo[1]), .match_cnt(c1));
    dylock_unlock_ctrl #(.KEY_W(32), .THRESH(3), .MAX_FAIL(0), .STICKY(0)) u2 (
        .clk(clk), .rst(rst), .key_valid(vld[2]), .static_key(key[2]),
        .correct_tk(rf[2]), .set(d_set[2]), .match(d_match[2]),
        .lockout(d_lo[2]), .match_cnt(c2));
    dylock_unlock_ctrl #(.KEY_W(4), .THRESH(1), .MAX_FAIL(2), .STICKY(0)) u3 (
        .clk(clk), .rst(rst), .key_valid(vld[3]), .static_key(key[3][3:0]),
        .correct_tk(rf[3][3:0]), .set(d_set[3]), .match(d_match[3]),
        .lockout(d_lo[3]), .match_cnt(c3));

    function automatic logic [31:0] xform(input logic [31:0] k);
        logic [31:0] r;
        for (int n = 0; n < 8; n++) r[4*n +: 4] = 4'(sb[k[4*n +: 4]]);
        return r;
    endfunction

    function automatic logic [31:0] wmask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << w) - 64'd1);
    endfunction

    function automatic int dcnt(input int i);
        case (i)
            0:       return int'(c0);
            1:       return int'(c1);
            2:       return int'(c2);
            default: return int'(c3);
        endcase
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Behavioural model: counts and flags per instance, one pending sample.
    int m_cnt  [NDUT];
    int m_fail [NDUT];
    bit m_unl  [NDUT];
    bit m_lo   [NDUT];
    bit m_mat  [NDUT];
    bit p_v    [NDUT];
    bit p_h    [NDUT];

    task automatic bump(input int i);
        if (mf[i] > 0) begin
            if (m_fail[i] < mf[i]) m_fail[i]++;
            if (m_fail[i] >= mf[i]) begin
                m_lo[i]  = 1'b1;
                m_unl[i] = 1'b0;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < NDUT; i++) begin
            if (rst) begin
                m_cnt[i] = 0; m_fail[i] = 0; m_unl[i] = 0; m_lo[i] = 0;
                m_mat[i] = 0; p_v[i] = 0; p_h[i] = 0;
            end else begin
                m_mat[i] = p_v[i] && p_h[i];
                if (p_v[i] && !m_lo[i]) begin
                    if (m_unl[i]) begin
                        if (st[i] == 0 && !p_h[i]) begin
                            m_unl[i] = 1'b0;
                            m_cnt[i] = 0;
                            bump(i);
                        end
                    end else if (p_h[i]) begin
                        m_cnt[i]++;
                        if (m_cnt[i] >= th[i]) begin
                            m_cnt[i]  = th[i];
                            m_unl[i]  = 1'b1;
                            m_fail[i] = 0;
                        end
                    end else begin
                        m_cnt[i] = 0;
                        bump(i);
                    end
                end
                p_v[i] = vld[i];
                p_h[i] = ((xform(key[i]) ^ rf[i]) & wmask(kw[i])) == 32'd0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NDUT; i++) begin
                check($sformatf("d%0d set", i),       int'(d_set[i]),   int'(m_unl[i]));
                check($sformatf("d%0d match", i),     int'(d_match[i]), int'(m_mat[i]));
                check($sformatf("d%0d lockout", i),   int'(d_lo[i]),    int'(m_lo[i]));
                check($sformatf("d%0d match_cnt", i), dcnt(i),          m_cnt[i]);
            end
        end
    end

    initial begin
        int pmiss;
        int pval;
        vld = '0;
        for (int i = 0; i < NDUT; i++) begin key[i] = '0; rf[i] = '0; end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        check("reset d0 set", int'(d_set[0]), 0);
        check("reset d1 cnt", dcnt(1), 0);

        vld = 4'b1111;
        key[0] = 32'h1234; rf[0] = 32'h4E82;
        key[1] = 32'h1234; rf[1] = 32'h4E83;
        key[2] = 32'h0;    rf[2] = 32'h8888_8888;
        key[3] = 32'h0;    rf[3] = 32'h8;
        for (int t = 1; t <= 13; t++) begin
            @(posedge clk); #1;
            case (t)
                1: begin
                    check("d0 cnt latency", dcnt(0), 0);
                    rf[3] = 32'h9;
                end
                2: begin
                    check("d0 cnt first hit", dcnt(0), 1);
                    check("d0 match first hit", int'(d_match[0]), 1);
                    check("model d0 cnt", m_cnt[0], 1);
                    check("d1 match on miss", int'(d_match[1]), 0);
                    check("d3 thresh1 set", int'(d_set[3]), 1);
                end
                3: begin
                    check("d1 lockout before 3rd", int'(d_lo[1]), 0);
                    check("d3 relock set", int'(d_set[3]), 0);
                    check("d3 lockout early", int'(d_lo[3]), 0);
                    rf[1] = 32'h4E82;
                    vld[2] = 1'b0;
                end
                4: begin
                    check("d1 lockout after 3rd", int'(d_lo[1]), 1);
                    check("model d1 lockout", int'(m_lo[1]), 1);
                    check("d2 unlock set", int'(d_set[2]), 1);
                    check("d2 cnt sat", dcnt(2), 3);
                    check("d3 lockout", int'(d_lo[3]), 1);
                end
                5: begin
                    vld[2] = 1'b1;
                    rf[2] = 32'h8888_8889;
                end
                6: begin
                    check("d2 set held", int'(d_set[2]), 1);
                    vld[2] = 1'b0;
                end
                7: begin
                    check("d2 relock set", int'(d_set[2]), 0);
                    check("d2 relock cnt", dcnt(2), 0);
                end
                8: begin
                    check("d0 cnt 7th", dcnt(0), 7);
                    check("d0 set before 8th", int'(d_set[0]), 0);
                    vld[0] = 1'b0;
                end
                9: begin
                    check("d0 cnt 8th", dcnt(0), 8);
                    check("d0 set after 8th", int'(d_set[0]), 1);
                end
                13: begin
                    check("d1 set in lockout", int'(d_set[1]), 0);
                    check("d1 cnt frozen", dcnt(1), 0);
                    check("d1 lockout held", int'(d_lo[1]), 1);
                end
                default: ;
            endcase
        end

        // Reset asserted between edges must clear outputs without a clock edge.
        @(posedge clk); #2 rst = 1'b1;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("async rst d%0d set", i),     int'(d_set[i]),   0);
            check($sformatf("async rst d%0d match", i),   int'(d_match[i]), 0);
            check($sformatf("async rst d%0d lockout", i), int'(d_lo[i]),    0);
            check($sformatf("async rst d%0d cnt", i),     dcnt(i),          0);
        end
        @(posedge clk); #1 rst = 1'b0;

        for (int seg = 0; seg < 12; seg++) begin
            pmiss = (seg % 3 == 0) ? 1 : ((seg % 3 == 1) ? 6 : 25);
            pval  = (seg % 2 == 0) ? 90 : 55;
            rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
            for (int c = 0; c < 250; c++) begin
                for (int i = 0; i < NDUT; i++) begin
                    vld[i] = ($urandom_range(0, 99) < pval);
                    key[i] = $urandom & wmask(kw[i]);
                    rf[i]  = xform(key[i]) & wmask(kw[i]);
                    if ($urandom_range(0, 99) < pmiss)
                        rf[i] = rf[i] ^ (32'd1 << $urandom_range(0, kw[i] - 1));
                end
                @(posedge clk); #1;
                rst = ($urandom_range(0, 299) == 0);
            end
        end

        rst = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dylock_unlock_ctrl.md
DYLOCK_UNLOCK_CTRL -- requirements
Module: dylock_unlock_ctrl

Interface
REQ-001 Parameter KEY_W, default 16, key width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 Parameter THRESH, default 8, consecutive valid matches needed to unlock; SHALL be at least 1.
REQ-003 Parameter MAX_FAIL, default 0, valid mismatches before permanent lockout; 0 disables lockout.
REQ-004 Parameter STICKY, default 1; 1 = unlock holds until reset, 0 = a valid mismatch relocks.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 key_valid  in  1  qualifies static_key/correct_tk this cycle.
REQ-008 static_key  in  KEY_W  static key, KEY_W/4 nibbles.
REQ-009 correct_tk  in  KEY_W  expected transformed key.
REQ-010 set  out  1  unlock indication (high = circuit unlocked).
REQ-011 match  out  1  registered per-sample compare result.
REQ-012 lockout  out  1  permanent lockout flag.
REQ-013 match_cnt  out  CNT_W  consecutive-hit count; CNT_W = clog2(THRESH+1).

Function
REQ-014 Each nibble i SHALL map TK[4i+3:4i] = SBOX(static_key[4i+3:4i]); SBOX 0..F -> 8,4,E,8,2,D,C,1,5,B,F,2,3,E,1,7.
REQ-015 Stage 1: every edge registers v1 = key_valid, tk1 = SBOX(static_key), ref1 = correct_tk.
REQ-016 hit = v1 and (tk1 == ref1); miss = v1 and not hit; match <= hit each edge (match = 0 when v1 = 0).
REQ-017 Latency: a sample at edge n affects match, match_cnt, state and set from edge n+1.
REQ-018 FSM states: LOCKED, ARMING, UNLOCKED, LOCKOUT; set = 1 only in UNLOCKED, lockout = 1 only in LOCKOUT.
REQ-019 LOCKED/ARMING on hit: match_cnt increments; reaching THRESH -> UNLOCKED, else -> ARMING.
REQ-020 LOCKED/ARMING on miss: match_cnt <= 0, state -> LOCKED, fail_cnt increments.
REQ-021 v1 = 0 SHALL hold match_cnt, fail_cnt and state (gaps do not break a run).
REQ-022 match_cnt SHALL saturate at THRESH; THRESH = 1 unlocks on the first hit.
REQ-023 Entering UNLOCKED SHALL clear fail_cnt.
REQ-024 UNLOCKED, STICKY = 1: inputs ignored; state, set and match_cnt held until rst.
REQ-025 UNLOCKED, STICKY = 0, miss: -> LOCKED, match_cnt <= 0, fail_cnt increments; hit holds state.
REQ-026 fail_cnt (internal, saturating, width clog2(MAX_FAIL+1)) reaching MAX_FAIL (MAX_FAIL > 0) SHALL enter LOCKOUT on that same edge, overriding REQ-020/REQ-025 targets.
REQ-027 LOCKOUT SHALL ignore all inputs, freeze match_cnt, hold set = 0, and leave only on rst.

Reset
REQ-028 rst asserted SHALL immediately force state = LOCKED, set = 0, match = 0, lockout = 0, match_cnt = 0, fail_cnt = 0, and clear stage-1 registers.
REQ-029 rst mid-run or in UNLOCKED/LOCKOUT SHALL discard all progress; the first sample after rst release counts from 0.

Structure
REQ-030 Package dylock_pkg SHALL hold the SBOX table constant and the FSM state enum.
REQ-031 One sub-module dylock_sbox4 (4-bit in, 4-bit out, combinational) SHALL be instantiated KEY_W/4 times.
REQ-032 Parameter legality (KEY_W % 4, THRESH >= 1) SHALL be checked at elaboration.

Verification
REQ-033 Reset: assert rst mid-clock -> set, match, lockout, match_cnt all 0 without a clock edge.
REQ-034 static_key = 16'h1234, correct_tk = 16'h4E82, key_valid = 1 for 8 cycles -> match_cnt 1..8; set rises at the edge after the 8th sample.
REQ-035 7 hits, then correct_tk = 16'h4E83 -> match_cnt = 0, set = 0, state LOCKED; 8 further hits unlock.
REQ-036 Hits interleaved with key_valid = 0 cycles -> match_cnt holds across gaps; unlocks after the 8th valid hit.
REQ-037 MAX_FAIL = 3, three misses -> lockout = 1 after the 3rd; 8 later hits leave set = 0; rst clears lockout.
REQ-038 STICKY = 0, KEY_W = 32, static_key = 32'h0000_0000, correct_tk = 32'h8888_8888 -> unlock; one miss -> set = 0 at the next edge.
